// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Fetch FSM states, opcode constants and instruction field helpers.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    DROP
  } fetch_state_e;

  localparam logic [5:0] BUBBLE_OPCODE = 6'b111111;
  localparam logic [5:0] OP_RTYPE      = 6'b000000;
  localparam logic [5:0] OP_LW         = 6'b100011;
  localparam logic [5:0] OP_SW         = 6'b101011;
  localparam logic [5:0] OP_BEQ        = 6'b000100;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  function automatic logic [5:0] opcode_of(
    input logic [31:0] instr
  );
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/if_id_fetch_stage_if_id_reg.sv
// Pipeline register with load/hold/flush; the MSB is the valid bit.
// Neither load nor hold inserts a bubble by clearing only the valid bit.
module if_id_reg #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         hold,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (!hold) begin
      q[W-1] <= 1'b0;
    end
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Single outstanding imem request, skid buffer for stalled responses.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [5:0]  BUBBLE_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic [5:0]  ifid_opcode_o,
  output logic        fetch_busy_o
);
  import mips_pkg::*;

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] skid_q;
  logic        skid_full;
  logic        take_resp;
  logic        capture;
  logic        release_buf;
  logic        deliver;
  if_id_t      ifid_d;
  if_id_t      ifid_q;

  assign pc4 = pc + 32'd4;

  assign take_resp = (state_q == WAIT) && imem_valid_i
                   && !branch_taken_i && !stall_i;
  assign capture = (state_q == WAIT) && imem_valid_i
                 && !branch_taken_i && stall_i;
  assign release_buf = (state_q == HOLD) && skid_full
                     && !branch_taken_i && !stall_i;
  assign deliver = take_resp || release_buf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush outranks stall and any response arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: state_d = branch_taken_i ? DROP : WAIT;
      WAIT: begin
        if (imem_valid_i) begin
          if (branch_taken_i || !stall_i) state_d = FETCH;
          else                            state_d = HOLD;
        end else if (branch_taken_i) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (branch_taken_i || !stall_i) state_d = FETCH;
      end
      DROP: begin
        if (imem_valid_i) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_o   = 1'b0;
    fetch_busy_o = 1'b0;
    unique case (state_q)
      FETCH:      imem_req_o   = 1'b1;
      WAIT, DROP: fetch_busy_o = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      skid_q    <= '0;
      skid_full <= 1'b0;
    end else begin
      if (branch_taken_i) pc <= branch_target_i;
      else if (deliver)   pc <= pc4;
      if (branch_taken_i || release_buf) begin
        skid_full <= 1'b0;
      end else if (capture) begin
        skid_full <= 1'b1;
        skid_q    <= imem_rdata_i;
      end
    end
  end

  always_comb begin
    ifid_d.valid = 1'b1;
    ifid_d.instr = take_resp ? imem_rdata_i : skid_q;
    ifid_d.pc4   = pc4;
  end

  if_id_reg #(.W(65)) u_ifid (
    .clk   (clk),
    .reset (reset),
    .load  (deliver),
    .hold  (stall_i),
    .flush (branch_taken_i),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_addr_o   = pc;
  assign ifid_valid_o  = ifid_q.valid;
  assign ifid_instr_o  = ifid_q.instr;
  assign ifid_pc4_o    = ifid_q.pc4;
  assign ifid_opcode_o = ifid_q.valid ? opcode_of(ifid_q.instr)
                                      : BUBBLE_OPCODE;

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the control decoder.
- Owns the PC and issues single-outstanding requests to instruction memory, which may take several cycles to respond.
- Registers the returned instruction and presents its opcode field to the control decoder.
- Honours the hazard-unit stall and the branch-resolution flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUBBLE_OPCODE, 6'b111111, opcode driven when IF/ID holds no valid instruction; the control decoder maps it to all-zero control bits.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- stall_i  in  1  hazard unit: hold IF/ID and PC
- branch_taken_i  in  1  branch resolved taken (from EX/MEM)
- branch_target_i  in  32  branch destination
- imem_req_o  out  1  one-cycle fetch request pulse
- imem_addr_o  out  32  fetch address (the PC)
- imem_valid_i  in  1  instruction-memory response valid
- imem_rdata_i  in  32  instruction word
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_instr_o  out  32  registered instruction
- ifid_pc4_o  out  32  PC+4 of the registered instruction
- ifid_opcode_o  out  6  instr[31:26] if valid, else BUBBLE_OPCODE
- fetch_busy_o  out  1  request outstanding (state WAIT or DROP)

Behaviour:
- Reset is asynchronous and active-high. Values while reset is high:
  - pc = RESET_PC, state = IDLE.
  - ifid_valid_o = 0, ifid_instr_o = 0, ifid_pc4_o = 0.
  - Skid buffer is empty.
  - imem_req_o = 0, fetch_busy_o = 0.
- Reset asserted mid-operation discards any outstanding response. Any imem_valid_i seen while in IDLE is ignored.
- States: IDLE, FETCH, WAIT, HOLD, DROP.
  - IDLE: moves to FETCH after one cycle. The first request therefore appears in the 2nd cycle after reset deasserts.
  - FETCH: imem_req_o = 1 and imem_addr_o = pc for exactly one cycle, then move to WAIT.
  - WAIT: waits for imem_valid_i.
    - Valid with stall_i = 0: load IF/ID with {valid = 1, instr = rdata, pc4 = pc + 4}; pc <= pc + 4; move to FETCH.
    - Valid with stall_i = 1: capture rdata in the 1-entry skid buffer; move to HOLD.
  - HOLD: wait for stall_i = 0. Then load IF/ID from the buffer, pc <= pc + 4, move to FETCH.
  - DROP: wait for imem_valid_i; discard the data and move to FETCH.
- While stall_i = 1, the IF/ID register and pc are unchanged. Exception: a branch flush, below.
- When the stall is released from WAIT or HOLD, IF/ID loads the new instruction. With stall_i = 0 and no new instruction, ifid_valid_o clears to 0 (a bubble).
- Branch flush (branch_taken_i = 1) takes priority over stall and over a same-cycle response:
  - pc <= branch_target_i.
  - ifid_valid_o <= 0 and ifid_instr_o <= 0.
  - Buffer is emptied.
  - State transitions on branch:
    - WAIT without imem_valid_i in the same cycle: go to DROP.
    - WAIT with imem_valid_i in the same cycle: the response is discarded and the stage goes to FETCH.
    - HOLD: go to FETCH.
    - FETCH: the request already issued is for the stale pc, so go to DROP.
    - IDLE: unchanged.
- Arithmetic: pc + 4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). pc[1:0] is never checked.
- Throughput: with 1-cycle memory the stage delivers one instruction per 2 cycles. Each N-cycle memory latency adds N-1 cycles.
- Outputs ifid_* are registered. ifid_opcode_o is combinational from the IF/ID register only.

Decomposition:
- Shared package mips_pkg holds:
  - State enum/localparams (IDLE, FETCH, WAIT, HOLD, DROP).
  - BUBBLE_OPCODE and the opcode constants R-type 000000, LW 100011, SW 101011, BEQ 000100.
  - Instruction field slices (opcode = [31:26]).
- One natural sub-module, if_id_reg: a 65-bit {valid, instr, pc4} register with load/hold/flush inputs. It is reusable for the ID/EX register.

Test Plan:
- Reset release with 1-cycle memory returning 32'h8C22_0004 at address 0:
  - imem_req_o high with addr 0 in cycle 2.
  - ifid_valid_o = 1, ifid_opcode_o = 100011, ifid_pc4_o = 4 in cycle 4.
  - Next request at addr 4.
- stall_i held for 3 cycles across a response:
  - IF/ID unchanged and state HOLD while the stall is held.
  - The buffered word reaches IF/ID the cycle after the stall drops.
  - pc advances exactly once.
- branch_taken_i with target 32'h0000_0040 while WAIT with 3-cycle latency:
  - Stale response discarded; ifid_valid_o = 0 and opcode = 111111.
  - Next request at addr 32'h40.
- branch_taken_i and stall_i asserted together in HOLD:
  - Flush wins; buffer emptied; request at the target on the next FETCH.
- pc = 32'hFFFF_FFFC, response 32'h1000_0003:
  - ifid_pc4_o = 0; next request at addr 0.
- reset asserted during WAIT, then the memory response arrives:
  - All outputs return to their reset values asynchronously.
  - The late imem_valid_i is ignored in IDLE.
  - Fetch restarts at RESET_PC.
